// File: rtl/lpddr4_lite_ctrl_if.sv
// Request/response handshake bundle between the SoC bus bridge and the
// LPDDR4-lite controller.
interface lpddr4_lite_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lpddr4_lite_ctrl.sv
// Single-word LPDDR4-lite initiator: decodes bus requests, drives registered
// command/data pins, and merges partial writes by read-modify-write.
module lpddr4_lite_ctrl #(
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 14,
    parameter bit          RMW_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lpddr4_lite_ctrl_if.slave     bus,
    output logic                  cs,
    output logic                  ras,
    output logic                  cas,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [2:0]            ba,
    inout  wire  [31:0]           dq,
    output logic [3:0]            dm,
    output logic                  dqs
);

    localparam int HI = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CMD  = 3'd1,
        RD_CMD  = 3'd2,
        RD_WAIT = 3'd3,
        TURN    = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            strb_q, strb_d;
    logic                  rmw_q, rmw_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  cmd_n_q, cmd_n_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            dm_q, dm_d;
    logic                  dqs_q, dqs_d;
    logic                  dq_oe_q, dq_oe_d;
    logic [31:0]           dq_out_q, dq_out_d;

    logic                  addr_err;
    logic                  wr_cmd;
    logic                  rd_cmd;

    // Bytes with strobe set come from the new write data, the rest from memory.
    function automatic logic [31:0] merge_bytes(input logic [3:0]  strb,
                                                input logic [31:0] wd,
                                                input logic [31:0] rd);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = strb[i] ? wd[8*i +: 8] : rd[8*i +: 8];
        end
        return m;
    endfunction

    assign addr_err = (bus.req_addr[1:0] != 2'b00) ||
                      (bus.req_addr[31:HI] != MEM_BASE[31:HI]);

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rmw_d   = rmw_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    waddr_d = bus.req_addr[ADDR_WIDTH+1:2];
                    wdata_d = bus.req_wdata;
                    strb_d  = bus.req_wstrb;
                    rmw_d   = 1'b0;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    if (addr_err) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (bus.req_we && (bus.req_wstrb == 4'h0)) begin
                        state_d = RESP;
                    end else if (bus.req_we &&
                                 ((bus.req_wstrb == 4'hF) || !RMW_EN)) begin
                        state_d = WR_CMD;
                    end else if (bus.req_we) begin
                        rmw_d   = 1'b1;
                        state_d = RD_CMD;
                    end else begin
                        state_d = RD_CMD;
                    end
                end
            end
            WR_CMD:  state_d = RESP;
            RD_CMD:  state_d = RD_WAIT;
            RD_WAIT: begin
                // The device drives dq during this cycle; capture at the exit edge.
                if (rmw_q) begin
                    wdata_d = merge_bytes(strb_q, wdata_q, dq);
                    state_d = TURN;
                end else begin
                    rdata_d = dq;
                    state_d = RESP;
                end
            end
            TURN: begin
                strb_d  = 4'hF;
                state_d = WR_CMD;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pins are registered from the next state so they line up with it.
        ready_d  = (state_d == IDLE);
        wr_cmd   = (state_d == WR_CMD);
        rd_cmd   = (state_d == RD_CMD);
        cmd_n_d  = ~(wr_cmd | rd_cmd);
        we_d     = ~wr_cmd;
        addr_d   = (wr_cmd || rd_cmd) ? waddr_d : '0;
        dm_d     = wr_cmd ? ~strb_d : 4'h0;
        dqs_d    = wr_cmd;
        dq_oe_d  = wr_cmd;
        dq_out_d = wr_cmd ? wdata_d : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= 32'h0;
            strb_q   <= 4'h0;
            rmw_q    <= 1'b0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            cmd_n_q  <= 1'b1;
            we_q     <= 1'b1;
            addr_q   <= '0;
            dm_q     <= 4'h0;
            dqs_q    <= 1'b0;
            dq_oe_q  <= 1'b0;
            dq_out_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            rmw_q    <= rmw_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cmd_n_q  <= cmd_n_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            dm_q     <= dm_d;
            dqs_q    <= dqs_d;
            dq_oe_q  <= dq_oe_d;
            dq_out_q <= dq_out_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    assign cs   = cmd_n_q;
    assign ras  = cmd_n_q;
    assign cas  = cmd_n_q;
    assign we   = we_q;
    assign addr = addr_q;
    assign ba   = 3'b000;
    assign dm   = dm_q;
    assign dqs  = dqs_q;
    assign dq   = dq_oe_q ? dq_out_q : 32'hzzzz_zzzz;

endmodule
